dual_ram_arbiter: RTL
=====================

Name: dual_ram_arbiter

Overview:
- Two-requester controller that shares the single-clock dual-port RAM block (separate read and write address ports, active-low chip select, registered read, tri-state output gated by `oe & !we`) between requester A and requester B.
- Arbitrates the read slot and the write slot independently with round-robin fairness.
- Sequences all RAM control signals, including the rule that `we` must be low while read data is being sampled.
- Returns read data to the requester that issued the read.

Parameters:
- D_WIDTH, 16, data width; must match the RAM.
- A_WIDTH, 6, address width; must match the RAM.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req_valid  in  1  requester A command valid
- a_req_ready  out  1  requester A command accepted when valid & ready at clk edge
- a_req_we  in  1  1 = write, 0 = read
- a_req_addr  in  A_WIDTH  command address
- a_req_wdata  in  D_WIDTH  write data
- a_rsp_valid  out  1  one-cycle pulse, read data for A
- a_rsp_data  out  D_WIDTH  read data for A
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_data: same as A, for requester B
- ram_cs  out  1  RAM chip select, active low
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_raddr  out  A_WIDTH  RAM read address
- ram_waddr  out  A_WIDTH  RAM write address
- ram_d  out  D_WIDTH  RAM write data
- ram_out  in  D_WIDTH  RAM data output; high-Z unless cs low, oe high, we low

Behaviour:
- Reset (async, rst=1):
  - Outputs: ram_cs=1, ram_we=0, ram_oe=0, ram_raddr=0, ram_waddr=0, ram_d=0, a/b_rsp_valid=0, a/b_rsp_data=0.
  - Internal state: pipeline flags cleared, both round-robin pointers favour A.
  - Reset mid-read discards the in-flight read; no response is ever produced for it.
- Slots: per cycle, at most one read and at most one write are accepted. A read and a write may be accepted in the same cycle, from the same or different requesters, if neither is blocked.
- Arbitration:
  - A requester presents one command per cycle, so it competes only in the slot matching req_we.
  - If only one requester wants a slot, it is granted.
  - If both want the same slot, the one favoured by that slot's pointer is granted. The pointer then flips to favour the other requester. The pointer is unchanged when there is no contention.
  - req_ready is combinational from valid, we, pointers and block state. It never depends on the requester's own ready.
- Pipeline (all RAM outputs registered):
  - Accept edge E0.
  - Cycle C1 (after E0), read: ram_raddr=addr, ram_oe=1, ram_cs=0; the RAM loads data_reg at edge E1.
  - Cycle C1, write: ram_waddr=addr, ram_d=wdata, ram_we=1, ram_cs=0; memory is written at E1.
  - Cycle C2 (capture), read: ram_oe=1, ram_we=0, ram_cs=0. ram_raddr holds its value unless a new read is issued in C2. ram_out is registered into the owner's rsp_data at E2.
  - Cycle C3: owner's rsp_valid=1 for exactly one cycle. Read latency is 3 cycles from accept edge to rsp_valid.
- Owner tag: one flag per pipeline stage (stage1 = issue, stage2 = capture), each with an owner bit.
- ram_oe = stage1 | stage2.
- ram_cs = !(ram_oe | ram_we). The RAM is deselected when idle.
- Write block: while stage1 is set, both write-slot readies are 0. A write accepted then would drive ram_we=1 in the capture cycle and tri-state ram_out.
  - Back-to-back reads are allowed at full rate (one per cycle).
  - A continuous read stream therefore starves writes. This is accepted behaviour; requesters must leave read bubbles.
- Same-address read and write issued in the same cycle return the old data (RAM read-before-write). A read issued the cycle after the write returns the new data.
- rsp_data holds its last value between pulses.
- The A and B responses never pulse in the same cycle, since only one read is issued per cycle.

Decomposition:
- Shared package: owner encoding constants (OWN_A=0, OWN_B=1) and the 3-cycle read latency constant.
- One natural sub-module: rr_arb2, a two-way round-robin grant with a pointer register. It is instantiated twice, once for the read slot and once for the write slot.

Test Plan:
- Reset then idle -> ram_cs=1, ram_oe=0, ram_we=0; both rsp_valid=0; both readies=1 when valid with we=1.
- A writes addr 5 = 0xBEEF; two cycles later A reads addr 5 -> a_rsp_valid pulses exactly 3 cycles after read accept with 0xBEEF; b_rsp_valid stays 0.
- A and B both read every cycle (addrs 1 and 2) -> grants alternate A, B, A, B; responses alternate with the correct data per owner; ram_oe continuously 1.
- A reads addr 3 while B writes addr 3 = 0x1234 in the same cycle (old value 0x0007) -> both accepted; A receives 0x0007; a subsequent read returns 0x1234.
- B write valid held in the cycle after A's read accept -> b_req_ready=0 in that cycle only; ram_we never 1 while stage2 is active; write completes the following cycle.
- Assert rst during C2 of an outstanding read -> no rsp_valid afterwards; all RAM outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/dual_ram_arbiter_pkg.sv
// dual_ram_arbiter_pkg: owner encoding and read latency shared by the arbiter and its bench
package dual_ram_arbiter_pkg;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;
  localparam int RD_LATENCY = 3;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer flips only on contention
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb begin
    gnt[0] = req[0] & (!req[1] | !ptr);
    gnt[1] = req[1] & (!req[0] | ptr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (&req) ptr <= ~ptr;
endmodule

// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: shares one registered-read dual-port RAM between requesters A and B
module dual_ram_arbiter
  import dual_ram_arbiter_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req_valid,
  output logic               a_req_ready,
  input  logic               a_req_we,
  input  logic [A_WIDTH-1:0] a_req_addr,
  input  logic [D_WIDTH-1:0] a_req_wdata,
  output logic               a_rsp_valid,
  output logic [D_WIDTH-1:0] a_rsp_data,
  input  logic               b_req_valid,
  output logic               b_req_ready,
  input  logic               b_req_we,
  input  logic [A_WIDTH-1:0] b_req_addr,
  input  logic [D_WIDTH-1:0] b_req_wdata,
  output logic               b_rsp_valid,
  output logic [D_WIDTH-1:0] b_rsp_data,
  output logic               ram_cs,
  output logic               ram_we,
  output logic               ram_oe,
  output logic [A_WIDTH-1:0] ram_raddr,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic [D_WIDTH-1:0] ram_d,
  input  logic [D_WIDTH-1:0] ram_out
);
  logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  logic s1_v, s2_v;
  owner_e s1_own, s2_own;
  // a write landing in the capture cycle would tri-state ram_out, so block writes during issue
  assign rd_req = {b_req_valid & !b_req_we, a_req_valid & !a_req_we};
  assign wr_req = {b_req_valid & b_req_we, a_req_valid & a_req_we} & {2{!s1_v}};
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));
  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));
  assign a_req_ready = a_req_we ? wr_gnt[0] : rd_gnt[0];
  assign b_req_ready = b_req_we ? wr_gnt[1] : rd_gnt[1];
  assign ram_oe = s1_v | s2_v;
  assign ram_cs = !(ram_oe | ram_we);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      s1_own      <= OWN_A;
      s2_own      <= OWN_A;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
      ram_we      <= 1'b0;
      ram_raddr   <= '0;
      ram_waddr   <= '0;
      ram_d       <= '0;
    end else begin
      s1_v        <= |rd_gnt;
      s1_own      <= rd_gnt[1] ? OWN_B : OWN_A;
      s2_v        <= s1_v;
      s2_own      <= s1_own;
      a_rsp_valid <= s2_v && s2_own == OWN_A;
      b_rsp_valid <= s2_v && s2_own == OWN_B;
      if (s2_v && s2_own == OWN_A) a_rsp_data <= ram_out;
      if (s2_v && s2_own == OWN_B) b_rsp_data <= ram_out;
      if (|rd_gnt) ram_raddr <= rd_gnt[1] ? b_req_addr : a_req_addr;
      ram_we <= |wr_gnt;
      if (|wr_gnt) begin
        ram_waddr <= wr_gnt[1] ? b_req_addr : a_req_addr;
        ram_d     <= wr_gnt[1] ? b_req_wdata : a_req_wdata;
      end
    end
endmodule
